// File: rtl/usb_uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : usb_uart_fifo_bridge (+ usb_uart_fifo_bridge_fifo)
// Purpose  : TX burst-batching FIFO and RX level-reporting FIFO around usb_uart
// Revision : 1.0 - initial release
// ============================================================================

module usb_uart_fifo_bridge_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       not_full,
  output logic                       not_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              not_full_q, not_full_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    not_full_d = (level_d != LW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      not_full_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      not_full_q <= not_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign not_full  = not_full_q;
  assign not_empty = (level_q != '0);

endmodule

module usb_uart_fifo_bridge #(
  parameter int DATA_W        = 8,
  parameter int TX_DEPTH      = 16,
  parameter int RX_DEPTH      = 16,
  parameter int TX_BURST      = 8,
  parameter int FLUSH_TIMEOUT = 480
) (
  input  logic                          clk_48mhz,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          tx_flush,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
  output logic [DATA_W-1:0]             uart_in_data,
  output logic                          uart_in_valid,
  input  logic                          uart_in_ready,
  input  logic [DATA_W-1:0]             uart_out_data,
  input  logic                          uart_out_valid,
  output logic                          uart_out_ready,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_level
);

  localparam int TLW = $clog2(TX_DEPTH+1);
  localparam int TW  = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT+1) : 1;
  localparam logic [TW-1:0]  TMO_MAX   = TW'(FLUSH_TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST  = (FLUSH_TIMEOUT > 0) ? TW'(FLUSH_TIMEOUT-1) : '0;
  localparam logic [TLW-1:0] BURST_LVL = TLW'(TX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } tx_state_e;

  tx_state_e      state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [TLW-1:0] tx_level_nxt;
  logic           tx_push, tx_pop, tx_not_empty;
  logic           rx_push, rx_pop;

  assign tx_push       = tx_valid && tx_ready;
  assign tx_pop        = uart_in_valid && uart_in_ready;
  assign uart_in_valid = (state_q == ST_DRAIN) && tx_not_empty;
  assign rx_push       = uart_out_valid && uart_out_ready;
  assign rx_pop        = rx_valid && rx_ready;

  usb_uart_fifo_bridge_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk_48mhz),
    .rst_n     (reset_n),
    .push      (tx_push),
    .wr_data   (tx_data),
    .pop       (tx_pop),
    .rd_data   (uart_in_data),
    .level     (tx_level),
    .not_full  (tx_ready),
    .not_empty (tx_not_empty)
  );

  usb_uart_fifo_bridge_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk_48mhz),
    .rst_n     (reset_n),
    .push      (rx_push),
    .wr_data   (uart_out_data),
    .pop       (rx_pop),
    .rd_data   (rx_data),
    .level     (rx_level),
    .not_full  (uart_out_ready),
    .not_empty (rx_valid)
  );

  // Level after this edge; the burst threshold is judged on it so that the
  // write reaching TX_BURST already triggers the drain.
  always_comb begin
    tx_level_nxt = tx_level;
    case ({tx_push, tx_pop})
      2'b10:   tx_level_nxt = tx_level + TLW'(1);
      2'b01:   tx_level_nxt = tx_level - TLW'(1);
      default: tx_level_nxt = tx_level;
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (tx_push) begin
          if ((FLUSH_TIMEOUT == 0) || (tx_level_nxt >= BURST_LVL)) state_d = ST_DRAIN;
          else                                                      state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (tx_push)                timer_d = '0;
        else if (timer_q != TMO_MAX) timer_d = timer_q + TW'(1);
        if ((tx_level_nxt >= BURST_LVL) || tx_flush ||
            (!tx_push && (FLUSH_TIMEOUT > 0) && (timer_q == TMO_LAST)))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        timer_d = '0;
        if (tx_level_nxt == '0) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

endmodule
`default_nettype wire
